// File: rtl/spi_master_mc_if.sv
// Bus-side and pad-side signals of the multi-slave SPI master.
// The master modport faces the SPI core; the slave modport faces the front-end driving it.
interface spi_master_mc_if #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DVSR_W = 16
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic [DATA_W-1:0] din;
    logic [DVSR_W-1:0] dvsr;
    logic              start;
    logic [SEL_W-1:0]  cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic              hold_cs;
    logic              miso;
    logic [DATA_W-1:0] dout;
    logic              done_tick;
    logic              ready;
    logic              sclk;
    logic [NUM_CS-1:0] ss_n;
    logic              mosi;

    modport master (
        input  din, dvsr, start, cs_sel, cpol, cpha, lsb_first, hold_cs, miso,
        output dout, done_tick, ready, sclk, ss_n, mosi
    );

    modport slave (
        output din, dvsr, start, cs_sel, cpol, cpha, lsb_first, hold_cs, miso,
        input  dout, done_tick, ready, sclk, ss_n, mosi
    );
endinterface

// File: rtl/spi_master_mc.sv
// Multi-slave SPI master: configurable width, bit order, SPI mode, CS setup/hold
// and burst mode where a slave select stays asserted across back-to-back words.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | ready for start; a held ss line may still be asserted
//   CS_SETUP | ss asserted, waiting one half-period before the first edge
//   CPHA_DLY | extra half-period of idle sclk when cpha=1
//   P0       | first half of a bit; miso sampled at its end
//   P1       | second half of a bit; mosi advances at its end
//   CS_HOLD  | ss still asserted one half-period after the last bit
module spi_master_mc #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DVSR_W = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    spi_master_mc_if.master bus
);
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, CS_SETUP, CPHA_DLY, P0, P1, CS_HOLD} state_t;

    state_t            state, state_nx;
    logic [DVSR_W-1:0] cnt, dvsr_r;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_r, rx_r;
    logic              cpol_r, cpha_r, lsb_r, hold_r;
    logic [SEL_W-1:0]  sel_r, held_sel_r;
    logic              held_r;
    logic [NUM_CS-1:0] ss_n_r, sel_mask;
    logic              sclk_r, mosi_r;
    logic              tc, last_bit, skip_setup, cpha_eff, cpol_eff, active;

    assign tc         = (cnt == dvsr_r);
    assign last_bit   = (bit_cnt == BIT_W'(DATA_W - 1));
    assign skip_setup = held_r && (held_sel_r == bus.cs_sel);
    assign cpha_eff   = (state == IDLE) ? bus.cpha : cpha_r;
    assign cpol_eff   = (state == IDLE) ? bus.cpol : cpol_r;

    // Out-of-range selects produce an all-ones mask, so the word runs with no slave chosen.
    always_comb begin
        sel_mask = '1;
        for (int i = 0; i < NUM_CS; i++) sel_mask[i] = (int'(bus.cs_sel) != i);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (bus.start) state_nx = skip_setup ? (bus.cpha ? CPHA_DLY : P0) : CS_SETUP;
            CS_SETUP: if (tc) state_nx = cpha_r ? CPHA_DLY : P0;
            CPHA_DLY: if (tc) state_nx = P0;
            P0:       if (tc) state_nx = P1;
            P1:       if (tc) state_nx = !last_bit ? P0 : (hold_r ? IDLE : CS_HOLD);
            CS_HOLD:  if (tc) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    assign active = ((state_nx == P1) && !cpha_eff) || ((state_nx == P0) && cpha_eff);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state      <= IDLE;
            cnt        <= '0;
            dvsr_r     <= '0;
            bit_cnt    <= '0;
            tx_r       <= '0;
            rx_r       <= '0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lsb_r      <= 1'b0;
            hold_r     <= 1'b0;
            sel_r      <= '0;
            held_r     <= 1'b0;
            held_sel_r <= '0;
            ss_n_r     <= '1;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= (tc || state == IDLE) ? '0 : cnt + 1'b1;
            sclk_r <= (state_nx == IDLE) ? bus.cpol : (cpol_eff ^ active);
            case (state)
                IDLE: if (bus.start) begin
                    dvsr_r  <= bus.dvsr;
                    cpol_r  <= bus.cpol;
                    cpha_r  <= bus.cpha;
                    lsb_r   <= bus.lsb_first;
                    hold_r  <= bus.hold_cs;
                    sel_r   <= bus.cs_sel;
                    bit_cnt <= '0;
                    tx_r    <= bus.din;
                    mosi_r  <= bus.lsb_first ? bus.din[0] : bus.din[DATA_W-1];
                    if (!skip_setup) begin
                        ss_n_r <= sel_mask;
                        held_r <= 1'b0;
                    end
                end
                P0: if (tc) begin
                    rx_r <= lsb_r ? {bus.miso, rx_r[DATA_W-1:1]} : {rx_r[DATA_W-2:0], bus.miso};
                end
                P1: if (tc) begin
                    if (!last_bit) begin
                        tx_r    <= lsb_r ? {1'b0, tx_r[DATA_W-1:1]} : {tx_r[DATA_W-2:0], 1'b0};
                        mosi_r  <= lsb_r ? tx_r[1] : tx_r[DATA_W-2];
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (hold_r) begin
                        held_r     <= 1'b1;
                        held_sel_r <= sel_r;
                    end
                end
                CS_HOLD: if (tc) begin
                    ss_n_r <= '1;
                    held_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.done_tick = tc && ((state == CS_HOLD) || ((state == P1) && last_bit && hold_r));
    assign bus.ready     = (state == IDLE);
    assign bus.dout      = rx_r;
    assign bus.sclk      = sclk_r;
    assign bus.ss_n      = ss_n_r;
    assign bus.mosi      = mosi_r;
endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: directed and randomized words checked against a
// word-level model of latency, received data, shifted-out bits and select behaviour.
module tb_spi_master_mc;
    localparam int DW  = 8;
    localparam int NCS = 4;
    localparam int DVW = 16;

    logic clk_i = 1'b0;
    logic reset_i;
    always #5 clk_i = ~clk_i;

    spi_master_mc_if #(.DATA_W(DW), .NUM_CS(NCS), .DVSR_W(DVW)) bus ();
    spi_master_mc #(.DATA_W(DW), .NUM_CS(NCS), .DVSR_W(DVW)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus));

    spi_master_mc_if #(.DATA_W(16), .NUM_CS(1), .DVSR_W(3)) bus16 ();
    spi_master_mc #(.DATA_W(16), .NUM_CS(1), .DVSR_W(3)) dut16 (
        .clk_i(clk_i), .reset_i(reset_i), .bus(bus16));

    logic loop_en, miso_drv;
    assign bus.miso   = loop_en ? bus.mosi : miso_drv;
    assign bus16.miso = bus16.mosi;

    int vectors = 0;
    int miscompares = 0;
    bit held_valid = 1'b0;
    int held_sel = 0;
    logic [NCS-1:0] all1 = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCS-1:0] mask_of(input int cs);
        logic [NCS-1:0] m;
        m = '1;
        if (cs < NCS) m[cs] = 1'b0;
        return m;
    endfunction

    // Bit k of a word in transmission order.
    function automatic logic stream_bit(input logic [DW-1:0] w, input bit lsb, input int k);
        return lsb ? w[k] : w[DW-1-k];
    endfunction

    task automatic xfer(input logic [DW-1:0] din, input int d, input int cs,
                        input bit cpol, input bit cpha, input bit lsb, input bit hold,
                        input bit loop, input bit perturb, input logic [DW-1:0] mword);
        logic [NCS-1:0] m;
        logic [DW-1:0]  cap, dout_seen, exp_dout;
        bit skip, ss_bad, got_done;
        logic prev;
        int exp_lat, cycles, edges;
        m        = mask_of(cs);
        skip     = held_valid && (held_sel == cs);
        exp_lat  = (d + 1) * (2 * DW + (skip ? 0 : 1) + int'(cpha) + (hold ? 0 : 1));
        exp_dout = loop ? din : mword;
        bus.din = din; bus.dvsr = DVW'(d); bus.cs_sel = cs[1:0];
        bus.cpol = cpol; bus.cpha = cpha; bus.lsb_first = lsb; bus.hold_cs = hold;
        loop_en = loop; miso_drv = stream_bit(mword, lsb, 0); bus.start = 1'b0;
        @(negedge clk_i);
        chk("pre_ss", bus.ss_n, held_valid ? mask_of(held_sel) : all1);
        chk("pre_ready", bus.ready, 1);
        bus.start = 1'b1;
        prev = bus.sclk; cycles = 0; edges = 0; cap = '0; ss_bad = 0; got_done = 0; dout_seen = 'x;
        while (!got_done && cycles < exp_lat + 50) begin
            @(negedge clk_i);
            cycles++;
            if (bus.ss_n !== m) ss_bad = 1;
            if (bus.sclk !== prev) begin
                if (bus.sclk === ~(cpol ^ cpha)) begin
                    if (edges < DW) cap[lsb ? edges : DW-1-edges] = bus.mosi;
                    edges++;
                    miso_drv = (edges < DW) ? stream_bit(mword, lsb, edges) : 1'b0;
                end
                prev = bus.sclk;
            end
            if (bus.done_tick === 1'b1) begin
                got_done = 1;
                dout_seen = bus.dout;
            end
            if (got_done) begin
                bus.start = 1'b0; bus.din = din; bus.dvsr = DVW'(d); bus.cs_sel = cs[1:0];
                bus.cpol = cpol; bus.cpha = cpha; bus.lsb_first = lsb; bus.hold_cs = hold;
            end else if (perturb) begin
                bus.start = 1'($urandom); bus.din = 8'($urandom); bus.dvsr = 16'($urandom_range(0, 7));
                bus.cs_sel = 2'($urandom); bus.cpol = 1'($urandom); bus.cpha = 1'($urandom);
                bus.lsb_first = 1'($urandom); bus.hold_cs = 1'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("done_seen", got_done, 1);
        chk("latency", cycles, exp_lat);
        chk("dout", dout_seen, exp_dout);
        chk("mosi_bits", cap, din);
        chk("sclk_edges", edges, DW);
        chk("ss_during", ss_bad, 0);
        @(negedge clk_i);
        chk("done_once", bus.done_tick, 0);
        chk("ready_after", bus.ready, 1);
        chk("ss_after", bus.ss_n, hold ? m : all1);
        chk("sclk_idle", bus.sclk, cpol);
        chk("dout_stable", bus.dout, exp_dout);
        held_valid = hold;
        held_sel   = cs;
    endtask

    task automatic xfer16(input logic [15:0] din, input int d, input bit cs);
        int exp_lat, cycles;
        bit got, ssb;
        logic [15:0] dv;
        exp_lat = (d + 1) * (2 * 16 + 1 + 1);
        bus16.din = din; bus16.dvsr = 3'(d); bus16.cs_sel = cs;
        bus16.cpol = 1'b0; bus16.cpha = 1'b0; bus16.lsb_first = 1'b0; bus16.hold_cs = 1'b0;
        @(negedge clk_i);
        bus16.start = 1'b1;
        cycles = 0; got = 0; ssb = 0; dv = 'x;
        while (!got && cycles < exp_lat + 50) begin
            @(negedge clk_i);
            cycles++;
            bus16.start = 1'b0;
            if (bus16.ss_n !== (cs ? 1'b1 : 1'b0)) ssb = 1;
            if (bus16.done_tick === 1'b1) begin
                got = 1;
                dv = bus16.dout;
            end
        end
        chk("w16_latency", cycles, exp_lat);
        chk("w16_dout", dv, din);
        chk("w16_ss", ssb, 0);
        @(negedge clk_i);
        chk("w16_ss_after", bus16.ss_n, 1);
        chk("w16_ready", bus16.ready, 1);
    endtask

    initial begin
        int e, n;
        logic prev;
        reset_i = 1'b1;
        bus.din = '0; bus.dvsr = '0; bus.start = 1'b0; bus.cs_sel = '0; bus.cpol = 1'b0;
        bus.cpha = 1'b0; bus.lsb_first = 1'b0; bus.hold_cs = 1'b0;
        bus16.din = '0; bus16.dvsr = '0; bus16.start = 1'b0; bus16.cs_sel = '0; bus16.cpol = 1'b0;
        bus16.cpha = 1'b0; bus16.lsb_first = 1'b0; bus16.hold_cs = 1'b0;
        loop_en = 1'b0; miso_drv = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_ss", bus.ss_n, all1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_mosi", bus.mosi, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_ready", bus.ready, 1);
        chk("rst_done", bus.done_tick, 0);
        reset_i = 1'b0;
        @(negedge clk_i);

        // Mode 0 loopback, then mode 3 LSB-first against a fixed slave word.
        xfer(8'hA5, 3, 1, 0, 0, 0, 0, 1, 0, 8'h00);
        xfer(8'h3C, 1, 0, 1, 1, 1, 0, 0, 0, 8'h96);

        // Burst on cs 2, then a switch from a held cs 2 to cs 0.
        xfer(8'($urandom), 2, 2, 0, 0, 0, 1, 1, 0, 8'h00);
        xfer(8'($urandom), 2, 2, 0, 0, 0, 0, 1, 0, 8'h00);
        xfer(8'($urandom), 1, 2, 0, 1, 0, 1, 0, 0, 8'($urandom));
        xfer(8'($urandom), 1, 0, 0, 1, 0, 0, 0, 0, 8'($urandom));

        // Inputs churning mid-transfer must not disturb the latched word.
        xfer(8'h5E, 2, 3, 0, 1, 1, 0, 1, 1, 8'h00);
        xfer(8'($urandom), 1, 1, 1, 0, 0, 0, 0, 1, 8'($urandom));

        for (int i = 0; i < 14; i++)
            xfer(8'($urandom), $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                 8'($urandom));
        if (held_valid) xfer(8'($urandom), 0, held_sel, 0, 0, 0, 0, 1, 0, 8'h00);

        // Asynchronous reset in the second half of bit 4.
        bus.din = 8'hC3; bus.dvsr = 16'd2; bus.cs_sel = 2'd3; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus.lsb_first = 1'b0; bus.hold_cs = 1'b0; loop_en = 1'b1;
        @(negedge clk_i);
        bus.start = 1'b1;
        prev = bus.sclk; e = 0; n = 0;
        while (e < 5 && n < 200) begin
            @(negedge clk_i);
            n++;
            bus.start = 1'b0;
            if (bus.sclk !== prev && bus.sclk === 1'b1) e++;
            prev = bus.sclk;
        end
        chk("rst_mid_reach", e, 5);
        chk("rst_mid_busy", bus.ready, 0);
        #2 reset_i = 1'b1;
        #1;
        chk("rst_mid_ss", bus.ss_n, all1);
        chk("rst_mid_sclk", bus.sclk, 0);
        chk("rst_mid_ready", bus.ready, 1);
        chk("rst_mid_done", bus.done_tick, 0);
        chk("rst_mid_mosi", bus.mosi, 0);
        chk("rst_mid_dout", bus.dout, 0);
        @(negedge clk_i);
        reset_i = 1'b0;
        held_valid = 1'b0;
        xfer(8'h69, 2, 3, 0, 0, 0, 0, 1, 0, 8'h00);

        // 16-bit single-slave instance: fastest clock, out-of-range select, largest divider.
        xfer16(16'hBEEF, 0, 1'b0);
        xfer16(16'($urandom), 0, 1'b1);
        xfer16(16'($urandom), 7, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
